// File: rtl/matrix_cell_sender.sv
// Buffers host cell writes in a FIFO and serialises them onto the matrix display
// cell interface with paced cell_en / update strobes. All logic runs on vclock.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting; pops the next cell, or starts a pending update
// S_SETUP   | cell_x/y/rgb driven, cell_en low (setup cycle)
// S_STROBE  | cell_en high for exactly one cycle
// S_GAP     | cell_en low for GAP_CYCLES cycles
// S_UPD     | update high for exactly one cycle
// S_UPD_GAP | update low for GAP_CYCLES cycles
module matrix_cell_sender #(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 16,
  parameter int B_WIDTH    = 4,
  parameter int B_HEIGHT   = 4,
  parameter int B_VGA      = 4,
  parameter int B_FIFO     = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  vclock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [B_WIDTH-1:0]    wr_x,
  input  logic [B_HEIGHT-1:0]   wr_y,
  input  logic [B_VGA*3-1:0]    wr_rgb,
  output logic                  wr_full,
  output logic                  wr_err,
  input  logic                  commit,
  output logic                  busy,
  output logic [B_VGA*3-1:0]    cell_rgb,
  output logic [B_WIDTH-1:0]    cell_x,
  output logic [B_HEIGHT-1:0]   cell_y,
  output logic                  cell_en,
  output logic                  update
);

  localparam int DEPTH  = 2**B_FIFO;
  localparam int B_CELL = B_WIDTH + B_HEIGHT + 3*B_VGA;
  localparam int B_GAP  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_UPD,
    S_UPD_GAP
  } state_t;

  logic [B_CELL-1:0]   fifo_mem [DEPTH];
  logic [B_FIFO-1:0]   wr_ptr;
  logic [B_FIFO-1:0]   rd_ptr;
  logic [B_FIFO:0]     count;
  logic                commit_pending;
  state_t              state;
  logic [B_GAP-1:0]    gap_cnt;

  logic [31:0]         x_ext;
  logic [31:0]         y_ext;
  logic                in_range;
  logic                push;
  logic                pop;
  logic [B_CELL-1:0]   head;

  // Coordinates are widened so the range check stays meaningful for any width.
  assign x_ext    = 32'(wr_x);
  assign y_ext    = 32'(wr_y);
  assign in_range = (x_ext < 32'(WIDTH)) && (y_ext < 32'(HEIGHT));

  assign wr_full  = (count == (B_FIFO+1)'(DEPTH));
  assign push     = wr_en && !wr_full && in_range;
  assign pop      = (state == S_IDLE) && (count != '0);
  assign head     = fifo_mem[rd_ptr];
  assign busy     = (count != '0) || commit_pending || (state != S_IDLE);

  always_ff @(posedge vclock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wr_x, wr_y, wr_rgb};
    end
  end

  always_ff @(posedge vclock) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      commit_pending <= 1'b0;
      state          <= S_IDLE;
      gap_cnt        <= '0;
      wr_err         <= 1'b0;
      cell_x         <= '0;
      cell_y         <= '0;
      cell_rgb       <= '0;
      cell_en        <= 1'b0;
      update         <= 1'b0;
    end else begin
      wr_err <= wr_en && !push;

      if (push) wr_ptr <= wr_ptr + B_FIFO'(1);
      if (pop)  rd_ptr <= rd_ptr + B_FIFO'(1);

      case ({push, pop})
        2'b10:   count <= count + (B_FIFO+1)'(1);
        2'b01:   count <= count - (B_FIFO+1)'(1);
        default: ;
      endcase

      cell_en <= 1'b0;
      update  <= 1'b0;

      case (state)
        S_IDLE: begin
          // Queued cells go out before any pending update.
          if (pop) begin
            {cell_x, cell_y, cell_rgb} <= head;
            state <= S_SETUP;
          end else if (commit_pending) begin
            commit_pending <= 1'b0;
            update         <= 1'b1;
            state          <= S_UPD;
          end
        end
        S_SETUP: begin
          cell_en <= 1'b1;
          state   <= S_STROBE;
        end
        S_STROBE: begin
          gap_cnt <= B_GAP'(GAP_CYCLES - 1);
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - B_GAP'(1);
        end
        S_UPD: begin
          gap_cnt <= B_GAP'(GAP_CYCLES - 1);
          state   <= S_UPD_GAP;
        end
        S_UPD_GAP: begin
          if (gap_cnt == '0) state <= S_IDLE;
          else               gap_cnt <= gap_cnt - B_GAP'(1);
        end
        default: state <= S_IDLE;
      endcase

      // A commit landing on the cycle an update starts arms another update.
      if (commit) commit_pending <= 1'b1;
    end
  end

endmodule
